// File: rtl/fib_index.sv
// fib_index: locates din in the Fibonacci sequence by iterative scan, reporting its index or the largest index below it.
module fib_index (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] din,
  input  logic        start,
  output logic [15:0] dout,
  output logic        is_fib,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state;
  logic [16:0] a, b;
  logic [4:0]  n;
  logic [15:0] target;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state  <= IDLE;
      dout   <= '0;
      is_fib <= 1'b0;
      done   <= 1'b0;
      a      <= 17'd0;
      b      <= 17'd1;
      n      <= '0;
      target <= '0;
    end else case (state)
      IDLE, DONE: if (start) begin
        target <= din;
        a      <= 17'd0;
        b      <= 17'd1;
        n      <= '0;
        done   <= 1'b0;
        is_fib <= 1'b0;
        state  <= RUN;
      end
      RUN: if (a == {1'b0, target}) begin
        dout   <= {11'd0, n};
        is_fib <= 1'b1;
        done   <= 1'b1;
        state  <= DONE;
      end else if (a > {1'b0, target}) begin
        // a has passed the target, so the previous index holds the largest F(k) below it
        dout   <= {11'd0, n - 5'd1};
        is_fib <= 1'b0;
        done   <= 1'b1;
        state  <= DONE;
      end else begin
        a <= b;
        b <= a + b;
        n <= n + 5'd1;
      end
      default: state <= IDLE;
    endcase
endmodule

// File: tb/tb_fib_index.sv
// tb_fib_index: directed table, corner sequences and a Fibonacci-neighbour sweep for fib_index.
module tb_fib_index;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] din, dout;
  logic        is_fib, done;
  int checks = 0, errors = 0;
  int fibtab [27];

  typedef struct {
    logic [15:0] din;
    int          dout;
    bit          fib;
    int          lat;
  } vec_t;
  vec_t vecs [12];

  fib_index dut (.clk(clk), .reset(reset), .din(din), .start(start), .dout(dout), .is_fib(is_fib), .done(done));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [15:0] d);
    din = d;
    start = 1'b1;
    tick;
    start = 1'b0;
    din = ~d;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!done && cnt < 40) begin
      tick;
      cnt++;
    end
  endtask

  task automatic pulse_reset;
    #2 reset = 1'b1;
    #1;
    chk("reset_outputs", {dout, is_fib, done}, 0);
    @(posedge clk);
    #3 reset = 1'b0;
  endtask

  task automatic run(input logic [15:0] d, input int ed, input bit ef, input int el, input bit hold);
    int cnt;
    bit ok;
    launch(d);
    chk($sformatf("done_cleared din=%0d", d), done, 0);
    wait_done(cnt);
    chk($sformatf("done din=%0d", d), done, 1);
    chk($sformatf("dout din=%0d", d), dout, ed);
    chk($sformatf("is_fib din=%0d", d), is_fib, ef);
    chk($sformatf("latency din=%0d", d), cnt, el);
    if (hold) begin
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
        din = 16'($urandom);
        tick;
        if (!done || dout != 16'(ed) || is_fib != ef) ok = 1'b0;
      end
      chk($sformatf("hold din=%0d", d), ok, 1);
    end
  endtask

  function automatic void model(input int d, output int idx, output bit f, output int lat);
    f = 1'b0;
    idx = 0;
    for (int k = 25; k >= 0; k--)
      if (fibtab[k] == d) begin
        idx = k;
        f = 1'b1;
      end
    if (!f)
      for (int k = 0; k <= 25; k++)
        if (fibtab[k] < d) idx = k;
    lat = f ? idx + 1 : idx + 2;
  endfunction

  task automatic sweep_one(input int d, input bit hold);
    int idx, lat;
    bit f;
    model(d, idx, f, lat);
    pulse_reset;
    run(16'(d), idx, f, lat, hold);
  endtask

  initial begin
    int cnt;
    bit seen;
    fibtab[0] = 0;
    fibtab[1] = 1;
    for (int k = 2; k < 27; k++) fibtab[k] = fibtab[k-1] + fibtab[k-2];
    vecs[0]  = '{16'd0,     0,  1'b1, 1};
    vecs[1]  = '{16'd1,     1,  1'b1, 2};
    vecs[2]  = '{16'd2,     3,  1'b1, 4};
    vecs[3]  = '{16'd46368, 24, 1'b1, 25};
    vecs[4]  = '{16'd4,     4,  1'b0, 6};
    vecs[5]  = '{16'd65535, 24, 1'b0, 26};
    vecs[6]  = '{16'd3,     4,  1'b1, 5};
    vecs[7]  = '{16'd5,     5,  1'b1, 6};
    vecs[8]  = '{16'd6,     5,  1'b0, 7};
    vecs[9]  = '{16'd100,   11, 1'b0, 13};
    vecs[10] = '{16'd13,    7,  1'b1, 8};
    vecs[11] = '{16'd610,   15, 1'b1, 16};

    reset = 1'b1;
    start = 1'b1;
    din = 16'd7;
    repeat (2) tick;
    chk("reset_with_start", {dout, is_fib, done}, 0);
    reset = 1'b0;
    start = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      tick;
      if (done) seen = 1'b1;
    end
    chk("idle_after_reset", seen, 0);

    foreach (vecs[i]) run(vecs[i].din, vecs[i].dout, vecs[i].fib, vecs[i].lat, 1'b1);

    launch(16'd610);
    tick;
    tick;
    din = 16'd5;
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_done(cnt);
    chk("run_start_dout", dout, 15);
    chk("run_start_is_fib", is_fib, 1);
    chk("run_start_latency", cnt + 3, 16);

    launch(16'd46368);
    repeat (10) tick;
    #2 reset = 1'b1;
    #1;
    chk("abort_outputs", {dout, is_fib, done}, 0);
    @(posedge clk);
    #3 reset = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      tick;
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", seen, 0);
    run(16'd13, 7, 1'b1, 8, 1'b1);

    for (int d = 0; d < 1024; d++) sweep_one(d, 1'b0);
    for (int k = 17; k <= 24; k++)
      for (int j = -1; j <= 1; j++) sweep_one(fibtab[k] + j, 1'b1);
    sweep_one(65534, 1'b1);
    sweep_one(65535, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
